// File: rtl/iir_pkg.sv
// Shared state encoding, coefficient layout and saturation helper
// for the time-multiplexed biquad cascade.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam int COEF_PER_SEC = 5;
    localparam int K_B0 = 0;
    localparam int K_B1 = 1;
    localparam int K_B2 = 2;
    localparam int K_A1 = 3;
    localparam int K_A2 = 4;

    localparam int SAT_W = 128;

    // Clamp a wide signed value into a w-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat(
        input logic signed [SAT_W-1:0] val,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        res = val;
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/biquad_section_dp.sv
// Combinational transposed DF-II biquad step (a0 = 1) for one section.
// Products and state stay full width; only the section output is clamped.
module biquad_section_dp
    import iir_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 27,
    localparam int ACC_W    = DATA_W + COEF_W
) (
    input  logic signed [DATA_W-1:0] v_i,
    input  logic signed [ACC_W-1:0]  z1_i,
    input  logic signed [ACC_W-1:0]  z2_i,
    input  logic signed [COEF_W-1:0] b0_i,
    input  logic signed [COEF_W-1:0] b1_i,
    input  logic signed [COEF_W-1:0] b2_i,
    input  logic signed [COEF_W-1:0] a1_i,
    input  logic signed [COEF_W-1:0] a2_i,
    output logic signed [DATA_W-1:0] u_o,
    output logic signed [ACC_W-1:0]  z1_o,
    output logic signed [ACC_W-1:0]  z2_o,
    output logic                     sat_o
);

    function automatic logic signed [ACC_W-1:0] sx(
        input logic signed [COEF_W-1:0] c
    );
        return {{DATA_W{c[COEF_W-1]}}, c};
    endfunction

    logic signed [ACC_W-1:0] v_e;
    logic signed [ACC_W-1:0] u_e;
    logic signed [ACC_W-1:0] pb0;
    logic signed [ACC_W:0]   acc;
    logic signed [ACC_W:0]   p;
    logic signed [SAT_W-1:0] p_w;
    logic signed [SAT_W-1:0] p_sat;

    assign v_e = {{COEF_W{v_i[DATA_W-1]}}, v_i};
    assign pb0 = sx(b0_i) * v_e;

    // One guard bit so z1 + b0*v cannot wrap before the shift.
    assign acc = {z1_i[ACC_W-1], z1_i} + {pb0[ACC_W-1], pb0};
    assign p   = acc >>> COEF_FRAC;

    assign p_w   = {{(SAT_W-ACC_W-1){p[ACC_W]}}, p};
    assign p_sat = sat(p_w, DATA_W);
    assign u_o   = p_sat[DATA_W-1:0];
    assign sat_o = (p_sat != p_w);

    assign u_e  = {{COEF_W{u_o[DATA_W-1]}}, u_o};
    assign z1_o = sx(b1_i) * v_e + z2_i - sx(a1_i) * u_e;
    assign z2_o = sx(b2_i) * v_e - sx(a2_i) * u_e;

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of N_SECT biquads sharing one datapath, one section per cycle,
// with run-time coefficient load, valid/ready handshake and saturation.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 27,
    parameter int N_SECT    = 4,
    localparam int N_COEF   = COEF_PER_SEC * N_SECT,
    localparam int AW       = $clog2(N_COEF),
    localparam int SW       = (N_SECT > 1) ? $clog2(N_SECT) : 1,
    localparam int ACC_W    = DATA_W + COEF_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     coef_err,
    input  logic                     hist_clr,
    output logic                     sat_flag
);

    localparam logic signed [COEF_W-1:0] B0_ONE = COEF_W'(64'd1 << COEF_FRAC);

    state_e                   state_q;
    logic [SW-1:0]            s_q;
    logic signed [DATA_W-1:0] v_q;
    logic signed [DATA_W-1:0] y_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     coef_err_q;
    logic                     sat_q;
    logic                     clr_pend_q;
    logic signed [COEF_W-1:0] coef_q [N_COEF];
    logic signed [ACC_W-1:0]  z1_q [N_SECT];
    logic signed [ACC_W-1:0]  z2_q [N_SECT];

    logic [AW-1:0]            base;
    logic signed [DATA_W-1:0] u_d;
    logic signed [ACC_W-1:0]  z1_d;
    logic signed [ACC_W-1:0]  z2_d;
    logic                     sat_d;
    logic                     wr_bad;
    logic                     wr_ok;
    logic                     last;

    assign base   = AW'(COEF_PER_SEC * int'(s_q));
    assign last   = (s_q == SW'(N_SECT - 1));
    assign wr_bad = coef_we &&
                    ((state_q != IDLE) || (coef_addr >= AW'(N_COEF)));
    assign wr_ok  = coef_we && !wr_bad;

    biquad_section_dp #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_dp (
        .v_i   (v_q),
        .z1_i  (z1_q[s_q]),
        .z2_i  (z2_q[s_q]),
        .b0_i  (coef_q[base + AW'(K_B0)]),
        .b1_i  (coef_q[base + AW'(K_B1)]),
        .b2_i  (coef_q[base + AW'(K_B2)]),
        .a1_i  (coef_q[base + AW'(K_A1)]),
        .a2_i  (coef_q[base + AW'(K_A2)]),
        .u_o   (u_d),
        .z1_o  (z1_d),
        .z2_o  (z2_d),
        .sat_o (sat_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            v_q         <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            sat_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= (i % COEF_PER_SEC == K_B0) ? B0_ONE : '0;
            end
            for (int i = 0; i < N_SECT; i++) begin
                z1_q[i] <= '0;
                z2_q[i] <= '0;
            end
        end else begin
            coef_err_q <= wr_bad;
            if (wr_ok) begin
                coef_q[coef_addr] <= coef_wdata;
            end
            unique case (state_q)
                IDLE: begin
                    // A clear requested mid-sample lands here, before the next one.
                    if (hist_clr || clr_pend_q) begin
                        for (int i = 0; i < N_SECT; i++) begin
                            z1_q[i] <= '0;
                            z2_q[i] <= '0;
                        end
                        sat_q      <= 1'b0;
                        clr_pend_q <= 1'b0;
                    end
                    if (in_valid) begin
                        v_q        <= x;
                        s_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (hist_clr) begin
                        clr_pend_q <= 1'b1;
                    end
                    z1_q[s_q] <= z1_d;
                    z2_q[s_q] <= z2_d;
                    v_q       <= u_d;
                    if (sat_d) begin
                        sat_q <= 1'b1;
                    end
                    if (last) begin
                        y_q         <= u_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        s_q <= s_q + SW'(1);
                    end
                end
                DONE: begin
                    if (hist_clr) begin
                        clr_pend_q <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign coef_err  = coef_err_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Scoreboard bench for iir_biquad_cascade against a longint reference model.
module tb_iir_biquad_cascade;

    localparam int N_SECT = 4;
    localparam int FRAC   = 27;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [31:0] coef_wdata;
    logic        coef_err;
    logic        hist_clr;
    logic        sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    longint      cf[N_SECT][5];
    longint      z1m[N_SECT];
    longint      z2m[N_SECT];

    iir_biquad_cascade #(
        .DATA_W    (32),
        .COEF_W    (32),
        .COEF_FRAC (FRAC),
        .N_SECT    (N_SECT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .hist_clr   (hist_clr),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint satm(input longint p);
        if (p > 64'sd2147483647) return 64'sd2147483647;
        if (p < -64'sd2147483648) return -64'sd2147483648;
        return p;
    endfunction

    function automatic logic [31:0] model_step(input int xv);
        longint v;
        longint p;
        longint u;
        v = longint'(xv);
        for (int s = 0; s < N_SECT; s++) begin
            p = (z1m[s] + cf[s][0] * v) >>> FRAC;
            u = satm(p);
            z1m[s] = cf[s][1] * v + z2m[s] - cf[s][3] * u;
            z2m[s] = cf[s][2] * v - cf[s][4] * u;
            v = u;
        end
        return v[31:0];
    endfunction

    task automatic model_clr();
        for (int s = 0; s < N_SECT; s++) begin
            z1m[s] = 0;
            z2m[s] = 0;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N_SECT; s++) begin
            for (int k = 0; k < 5; k++) cf[s][k] = (k == 0) ? (64'sd1 <<< FRAC) : 0;
        end
        model_clr();
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int a, input int d);
        coef_addr  = 5'(a);
        coef_wdata = d;
        coef_we    = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("coef_err_ok", {63'b0, coef_err}, 64'd0);
        cf[a / 5][a % 5] = longint'(d);
    endtask

    task automatic send(input int xv, input bit push);
        bit ok;
        if (push) q.push_back(model_step(xv));
        x        = xv;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check("accept", {63'b0, ok}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("sb_nonempty", {63'b0, q.size() != 0}, 64'd1);
            if (q.size() != 0) check("y", {32'b0, y}, {32'b0, q.pop_front()});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] hold;
        reset      = 1'b1;
        in_valid   = 1'b0;
        x          = '0;
        out_ready  = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        hist_clr   = 1'b0;
        model_reset();
        do_reset();

        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_y", {32'b0, y}, 64'd0);
        check("rst_coef_err", {63'b0, coef_err}, 64'd0);
        check("rst_sat", {63'b0, sat_flag}, 64'd0);

        // passthrough and latency
        send(1000, 1'b1);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("latency", 64'(lat), 64'(N_SECT + 1));
        drain();

        // band-pass section 0, impulse response
        wr_coef(0, 70062371);
        wr_coef(1, 0);
        wr_coef(2, -70062371);
        wr_coef(3, -113599717);
        wr_coef(4, -5907013);
        send(1 << 20, 1'b1);
        check("impulse_y0", {32'b0, q[0]}, 64'd547362);
        for (int i = 0; i < 7; i++) send(0, 1'b1);
        drain();
        hist_clr = 1'b1;
        model_clr();
        send(0, 1'b1);
        hist_clr = 1'b0;
        drain();

        // output stall
        out_ready = 1'b0;
        send(300000, 1'b1);
        hold = (q.size() != 0) ? q[0] : '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            check("stall_y", {32'b0, y}, {32'b0, hold});
            check("stall_in_ready", {63'b0, in_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // saturation
        do_reset();
        wr_coef(0, 4 << 27);
        send(32'h7FFFFFF0, 1'b1);
        check("sat_model", {32'b0, q[0]}, 64'h7FFFFFFF);
        drain();
        check("sat_flag_set", {63'b0, sat_flag}, 64'd1);
        hist_clr = 1'b1;
        @(posedge clk);
        #1;
        hist_clr = 1'b0;
        model_clr();
        check("sat_flag_clr", {63'b0, sat_flag}, 64'd0);

        // rejected coefficient writes
        do_reset();
        send(123, 1'b1);
        coef_addr  = 5'd0;
        coef_wdata = '0;
        coef_we    = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("err_busy", {63'b0, coef_err}, 64'd1);
        @(posedge clk);
        #1;
        check("err_busy_pulse", {63'b0, coef_err}, 64'd0);
        drain();
        coef_addr  = 5'(5 * N_SECT);
        coef_wdata = 32'h1234;
        coef_we    = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("err_range", {63'b0, coef_err}, 64'd1);
        @(posedge clk);
        #1;
        check("err_range_pulse", {63'b0, coef_err}, 64'd0);
        send(5000, 1'b1);
        drain();

        // async reset mid-CALC
        wr_coef(0, 2 << 27);
        send(21, 1'b1);
        drain();
        send(999, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst_in_ready", {63'b0, in_ready}, 64'd1);
        check("arst_out_valid", {63'b0, out_valid}, 64'd0);
        check("arst_y", {32'b0, y}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        send(7, 1'b1);
        check("arst_model", {32'b0, q[0]}, 64'd7);
        drain();

        check("sb_final", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
